// File: rtl/random_draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : random_draw_arbiter                                          |
// | Description : Round-robin sharing of one RNG among requesters; each grant  |
// |               gets a value below its bound via rejection sampling.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module random_draw_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LIMIT       = 15,
    parameter int MAX_RETRIES = 8,
    localparam int W          = $clog2(LIMIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         rng_value,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] bound,
    output logic [NUM_REQ-1:0]   ack,
    output logic [W-1:0]         draw_value,
    output logic                 fallback,
    output logic                 busy
);

    localparam int c_GW = $clog2(NUM_REQ);
    localparam int c_CW = $clog2(MAX_RETRIES + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DRAW = 2'd1;
    localparam logic [1:0] c_ACK  = 2'd2;

    localparam logic [c_CW-1:0] c_RETRY_LAST = c_CW'(MAX_RETRIES - 1);
    localparam logic [c_GW-1:0] c_LAST_INIT  = c_GW'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [c_GW-1:0]    r_grant;
    logic [c_GW-1:0]    r_last_grant;
    logic [W-1:0]       r_bound;
    logic [c_CW-1:0]    r_retry_cnt;

    logic               w_hi_found;
    logic [c_GW-1:0]    w_hi_idx;
    logic [c_GW-1:0]    w_lo_idx;
    logic [c_GW-1:0]    w_next_grant;
    logic [W-1:0]       w_bound_sel;
    logic [NUM_REQ-1:0] w_grant_onehot;

    // Lowest pending index above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (c_GW'(i) > r_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_GW'(i);
                end else begin
                    w_lo_idx   = c_GW'(i);
                end
            end
        end
        w_next_grant = w_hi_found ? w_hi_idx : w_lo_idx;

        w_bound_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (c_GW'(i) == w_next_grant) begin
                w_bound_sel = bound[i*W +: W];
            end
        end
    end

    assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_bound      <= '0;
            r_retry_cnt  <= '0;
            ack          <= '0;
            draw_value   <= '0;
            fallback     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|req) begin
                        r_grant     <= w_next_grant;
                        r_bound     <= w_bound_sel;
                        r_retry_cnt <= '0;
                        busy        <= 1'b1;
                        r_state     <= c_DRAW;
                    end
                end
                c_DRAW: begin
                    if (!req[r_grant]) begin
                        busy    <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (r_bound == '0) begin
                        draw_value <= '0;
                        fallback   <= 1'b1;
                        ack        <= w_grant_onehot;
                        r_state    <= c_ACK;
                    end else if (rng_value < r_bound) begin
                        draw_value <= rng_value;
                        fallback   <= 1'b0;
                        ack        <= w_grant_onehot;
                        r_state    <= c_ACK;
                    end else if (r_retry_cnt == c_RETRY_LAST) begin
                        draw_value <= '0;
                        fallback   <= 1'b1;
                        ack        <= w_grant_onehot;
                        r_state    <= c_ACK;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                    end
                end
                c_ACK: begin
                    ack          <= '0;
                    draw_value   <= '0;
                    fallback     <= 1'b0;
                    busy         <= 1'b0;
                    r_last_grant <= r_grant;
                    r_state      <= c_IDLE;
                end
                default: begin
                    ack        <= '0;
                    draw_value <= '0;
                    fallback   <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_random_draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_random_draw_arbiter                                       |
// | Description : Directed and randomized checks of random_draw_arbiter.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_random_draw_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int LIMIT       = 15;
    localparam int MAX_RETRIES = 8;
    localparam int W           = 4;

    logic                 clk;
    logic                 rst;
    logic [W-1:0]         rng_value;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*W-1:0] bound;
    logic [NUM_REQ-1:0]   ack;
    logic [W-1:0]         draw_value;
    logic                 fallback;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int m_last   = NUM_REQ - 1;
    int rng_seq [MAX_RETRIES];

    random_draw_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LIMIT      (LIMIT),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rng_value (rng_value),
        .req       (req),
        .bound     (bound),
        .ack       (ack),
        .draw_value(draw_value),
        .fallback  (fallback),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ack"},  32'(ack),        32'd0);
        chk({tag, "_val"},  32'(draw_value), 32'd0);
        chk({tag, "_fb"},   32'(fallback),   32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'd0);
    endtask

    // Reference: who wins, how many samples it takes, and what comes out.
    task automatic run_txn(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*W-1:0] b,
                           input bit scramble);
        int g, j, ev, ef, bg;
        g = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (m_last + k) % NUM_REQ;
            if (g < 0 && ((int'(r) >> idx) & 1) == 1) g = idx;
        end
        bg = (int'(b) >> (g * W)) & ((1 << W) - 1);
        j = -1; ev = 0; ef = 0;
        if (bg == 0) begin
            j = 0; ef = 1;
        end else begin
            for (int k = 0; k < MAX_RETRIES; k++)
                if (j < 0 && rng_seq[k] < bg) begin j = k; ev = rng_seq[k]; end
            if (j < 0) begin j = MAX_RETRIES - 1; ef = 1; end
        end

        req = r; bound = b;
        tick();
        chk("draw_entry_busy", 32'(busy), 32'd1);
        chk("draw_entry_ack",  32'(ack),  32'd0);
        for (int k = 0; k <= j; k++) begin
            rng_value = W'(rng_seq[k]);
            if (scramble) begin
                bound = NUM_REQ*W'($urandom);
                req   = NUM_REQ'($urandom) | (NUM_REQ'(1) << g);
            end
            tick();
            if (k == j) begin
                chk("ack_onehot", 32'(ack),        32'(1 << g));
                chk("ack_value",  32'(draw_value), 32'(ev));
                chk("ack_fb",     32'(fallback),   32'(ef));
                chk("ack_busy",   32'(busy),       32'd1);
            end else begin
                chk("retry_ack",  32'(ack),  32'd0);
                chk("retry_busy", 32'(busy), 32'd1);
            end
        end
        req = r;
        tick();
        chk_idle("post_ack");
        m_last = g;
    endtask

    task automatic do_reset(input logic [NUM_REQ-1:0] r);
        rst = 1'b1; req = r;
        tick();
        chk_idle("in_reset_a");
        tick();
        chk_idle("in_reset_b");
        rst = 1'b0;
        m_last = NUM_REQ - 1;
    endtask

    task automatic fill_seq(input int v);
        for (int k = 0; k < MAX_RETRIES; k++) rng_seq[k] = v;
    endtask

    initial begin
        rst = 1'b1; req = '0; bound = '0; rng_value = '0;

        // Basic draw straight after reset.
        bound = 16'h000A; rng_value = 4'd7;
        do_reset(4'b0001);
        fill_seq(7);
        run_txn(4'b0001, 16'h000A, 1'b0);

        // Rejection: 12 and 9 rejected, 3 accepted.
        fill_seq(15);
        rng_seq[0] = 12; rng_seq[1] = 9; rng_seq[2] = 3;
        run_txn(4'b0001, 16'h0005, 1'b0);

        // Fallback after exhausting retries, and immediate fallback on bound 0.
        fill_seq(14);
        run_txn(4'b0010, 16'h0020, 1'b0);
        run_txn(4'b0010, 16'h0000, 1'b0);

        // Round robin from reset with everybody requesting.
        do_reset(4'b0000);
        fill_seq(0);
        for (int n = 0; n < 5; n++) run_txn(4'b1111, 16'h9876, 1'b0);

        // Withdraw during DRAW: no ack, last_grant untouched.
        req = 4'b0100; bound = 16'h0900;
        tick();
        chk("wd_busy", 32'(busy), 32'd1);
        req = 4'b0000; rng_value = 4'd3;
        tick();
        chk_idle("withdraw");
        fill_seq(1);
        run_txn(4'b1111, 16'h5555, 1'b0);

        // Reset mid-draw, then requester 0 must be served first.
        req = 4'b1000; bound = 16'h3000;
        tick();
        chk("rst_draw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_idle("mid_reset");
        rst = 1'b0; m_last = NUM_REQ - 1;
        fill_seq(2);
        run_txn(4'b1111, 16'h3333, 1'b0);

        // Randomized traffic with input scrambling during DRAW.
        for (int n = 0; n < 40; n++) begin
            logic [NUM_REQ-1:0]   rr;
            logic [NUM_REQ*W-1:0] bb;
            rr = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            bb = NUM_REQ*W'($urandom);
            for (int k = 0; k < MAX_RETRIES; k++) rng_seq[k] = $urandom_range(0, LIMIT);
            run_txn(rr, bb, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
